// File: rtl/mult_uint11b_if.sv
// rtl/mult_uint11b_if.sv - operand/product bundle for the 11x11 unsigned multiplier.
interface mult_uint11b_if #(
  parameter int BIT_WIDTH = 11,
  parameter int OUT_WIDTH = 22
);
  logic                 in_valid;
  logic [BIT_WIDTH-1:0] in_a;
  logic [BIT_WIDTH-1:0] in_b;
  logic                 out_valid;
  logic [OUT_WIDTH-1:0] out;

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    input  out_valid,
    input  out
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    output out_valid,
    output out
  );
endinterface

// File: rtl/mult_uint11b.sv
// rtl/mult_uint11b.sv - exact 11x11 unsigned multiplier, carry-save tree + CPA, 2-cycle latency.
// The reduction tree below is laid out for exactly 11 partial-product rows.
module mult_uint11b #(
  parameter int BIT_WIDTH = 11,
  parameter int OUT_WIDTH = 22
) (
  input  logic            clk,
  input  logic            rst_n,
  mult_uint11b_if.slave   bus
);

  typedef logic [OUT_WIDTH-1:0] row_t;

  // 3:2 compressor over whole rows; the carry out of the top bit is dropped
  // because the true product always fits in OUT_WIDTH bits.
  function automatic logic [2*OUT_WIDTH-1:0] csa(input row_t x, input row_t y, input row_t z);
    row_t s;
    row_t c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {s, c};
  endfunction

  row_t pp [BIT_WIDTH];
  row_t l1 [8];
  row_t l2 [6];
  row_t l3 [4];
  row_t l4 [3];

  row_t sum_d, sum_q;
  row_t carry_d, carry_q;
  logic s1_valid_d, s1_valid_q;
  row_t out_d, out_q;
  logic out_valid_d, out_valid_q;

  always_comb begin
    for (int j = 0; j < BIT_WIDTH; j++) begin
      pp[j] = row_t'(bus.in_a & {BIT_WIDTH{bus.in_b[j]}}) << j;
    end

    // 11 -> 8 -> 6 -> 4 -> 3 -> 2 rows
    {l1[0], l1[1]} = csa(pp[0], pp[1], pp[2]);
    {l1[2], l1[3]} = csa(pp[3], pp[4], pp[5]);
    {l1[4], l1[5]} = csa(pp[6], pp[7], pp[8]);
    l1[6] = pp[9];
    l1[7] = pp[10];

    {l2[0], l2[1]} = csa(l1[0], l1[1], l1[2]);
    {l2[2], l2[3]} = csa(l1[3], l1[4], l1[5]);
    l2[4] = l1[6];
    l2[5] = l1[7];

    {l3[0], l3[1]} = csa(l2[0], l2[1], l2[2]);
    {l3[2], l3[3]} = csa(l2[3], l2[4], l2[5]);

    {l4[0], l4[1]} = csa(l3[0], l3[1], l3[2]);
    l4[2] = l3[3];

    {sum_d, carry_d} = csa(l4[0], l4[1], l4[2]);
    s1_valid_d = bus.in_valid;

    out_d       = sum_q + carry_q;
    out_valid_d = s1_valid_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      carry_q     <= '0;
      s1_valid_q  <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      s1_valid_q  <= s1_valid_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mult_uint11b.sv
// tb/tb_mult_uint11b.sv - scoreboard bench for mult_uint11b against a plain a*b model.
module tb_mult_uint11b;

  typedef struct {
    int          due;
    bit          v;
    logic [21:0] p;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ncnt  = 0;
  exp_t exp_q[$];

  mult_uint11b_if #(.BIT_WIDTH(11), .OUT_WIDTH(22)) bus ();

  mult_uint11b #(.BIT_WIDTH(11), .OUT_WIDTH(22)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one operand pair; the model result becomes visible one negedge after the next edge.
  task automatic issue(input bit v, input int a, input int b);
    exp_t e;
    bus.in_valid = v;
    bus.in_a     = 11'(a);
    bus.in_b     = 11'(b);
    @(posedge clk);
    if (rst_n) begin
      e.due = ncnt + 2;
      e.v   = v;
      e.p   = 22'(a * b);
      exp_q.push_back(e);
    end
    #1;
  endtask

  // Monitor: every negedge, either a scheduled result is due or out_valid must be low.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      ncnt++;
      if (!rst_n) begin
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_out", 32'(bus.out), 32'd0);
      end else if (exp_q.size() != 0 && exp_q[0].due <= ncnt) begin
        e = exp_q.pop_front();
        chk("due_slot", 32'(e.due), 32'(ncnt));
        chk("out_valid", 32'(bus.out_valid), 32'(e.v));
        if (e.v) chk("product", 32'(bus.out), 32'(e.p));
      end else begin
        chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
      end
    end
  end

  initial begin
    int ca[4];
    int cb[4];
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a     = 11'd5;
    bus.in_b     = 11'd7;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) issue(1, 5, 7);

    ca = '{0, 1, 1024, 2047};
    cb = '{2047, 2047, 1024, 2047};
    for (int i = 0; i < 4; i++) begin
      issue(1, ca[i], cb[i]);
      issue(0, 0, 0);
    end

    issue(1, 1234, 567);
    issue(1, 2047, 1);
    issue(1, 3, 3);
    issue(1, 1000, 2000);

    issue(1, 10, 10);
    issue(0, int'($urandom_range(2047)), int'($urandom_range(2047)));
    issue(1, 20, 20);

    // Two results in flight when reset hits between edges; neither may surface.
    issue(1, 2047, 2047);
    issue(1, 1500, 1700);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("async_reset_out", 32'(bus.out), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(0, 9, 9);
    issue(1, 33, 44);

    for (int i = 0; i < 20000; i++) begin
      issue(1, int'($urandom_range(2047)), int'($urandom_range(2047)));
    end
    for (int i = 0; i < 2000; i++) begin
      issue(($urandom_range(3) != 0), int'($urandom_range(2047)), int'($urandom_range(2047)));
    end

    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
